cp0_reg: RTL and testbench

Coprocessor-0 register block for the five-level pipeline: holds Count, Compare, Status, Cause and EPC, raises the internal timer interrupt, and encodes pending events into the `excptype` word consumed by the exception controller. It is the source end of the `excptype`/`epc` path and the sink of the controller's `excpt` acknowledge. It updates EPC, Status and Cause on the clock edge where an exception or return is taken. `mtc0` and `mfc0` reach it from the MEM stage.

---
 rtl/cp0_reg.sv | 119 +++++++++++
 tb/tb_cp0_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
// Coprocessor-0 register block: Count/Compare timer, Status, Cause and EPC,
// with combinational exception encoding and same-cycle mtc0 bypass on reads.
module cp0_reg #(
    parameter bit TIMER_VEC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [31:0] pc_i,
    input  logic        syscall_i,
    input  logic        eret_i,
    input  logic        excpt,
    output logic [31:0] excptype,
    output logic [31:0] epc,
    output logic        timer_int
);
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    localparam logic [31:0] EXC_TIMER   = 32'h0000_0004;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
    localparam logic [31:0] EXC_ERET    = 32'h0000_0200;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic        ip7_q, ip7_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        timer_match, take_timer, take_sys, take_eret;
    logic [31:0] cause_rd;

    assign wr_count   = we && (waddr == ADDR_COUNT);
    assign wr_compare = we && (waddr == ADDR_COMPARE);
    assign wr_status  = we && (waddr == ADDR_STATUS);
    assign wr_cause   = we && (waddr == ADDR_CAUSE);
    assign wr_epc     = we && (waddr == ADDR_EPC);

    assign cause_rd  = {16'b0, ip7_q, 5'b0, ip_sw_q, 1'b0, exc_code_q, 2'b0};
    assign timer_int = ip7_q;

    always_comb begin
        excptype = 32'h0;
        if (ip7_q && status_q[15] && status_q[0] && !status_q[1])
            excptype = EXC_TIMER;
        else if (syscall_i && !status_q[1])
            excptype = EXC_SYSCALL;
        else if (eret_i)
            excptype = EXC_ERET;
    end

    assign take_timer  = excpt && (excptype == EXC_TIMER);
    assign take_sys    = excpt && (excptype == EXC_SYSCALL);
    assign take_eret   = excpt && (excptype == EXC_ERET);
    assign timer_match = TIMER_VEC_EN && (count_q == compare_q) && (compare_q != 32'h0);

    // Exception effects are applied after the mtc0 value so they win on the
    // fields they touch while other written bits still land.
    always_comb begin
        count_d    = wr_count ? wdata : count_q + 32'd1;
        compare_d  = wr_compare ? wdata : compare_q;
        ip7_d      = wr_compare ? 1'b0 : (timer_match ? 1'b1 : ip7_q);
        status_d   = wr_status ? wdata : status_q;
        ip_sw_d    = wr_cause ? wdata[9:8] : ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = wr_epc ? wdata : epc_q;
        if (take_timer || take_sys) begin
            status_d[1] = 1'b1;
            epc_d       = pc_i;
            exc_code_d  = take_sys ? 5'd8 : 5'd0;
        end else if (take_eret) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            status_q   <= 32'h0000_8001;
            epc_q      <= 32'h0;
            ip7_q      <= 1'b0;
            ip_sw_q    <= 2'b0;
            exc_code_q <= 5'b0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            ip7_q      <= ip7_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (raddr)
            ADDR_COUNT:   rdata = wr_count ? wdata : count_q;
            ADDR_COMPARE: rdata = wr_compare ? wdata : compare_q;
            ADDR_STATUS:  rdata = wr_status ? wdata : status_q;
            ADDR_CAUSE:   rdata = wr_cause ? {cause_rd[31:10], wdata[9:8], cause_rd[7:0]} : cause_rd;
            ADDR_EPC:     rdata = wr_epc ? wdata : epc_q;
            default:      rdata = 32'h0;
        endcase
    end

    assign epc = wr_epc ? wdata : epc_q;
endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] pc_i;
    logic        syscall_i;
    logic        eret_i;
    logic        excpt;
    logic [31:0] excptype;
    logic [31:0] epc;
    logic        timer_int;

    localparam int K_RD = 0;
    localparam int K_XT = 1;
    localparam int K_EP = 2;
    localparam int K_TI = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    cp0_reg #(.TIMER_VEC_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .pc_i      (pc_i),
        .syscall_i (syscall_i),
        .eret_i    (eret_i),
        .excpt     (excpt),
        .excptype  (excptype),
        .epc       (epc),
        .timer_int (timer_int)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_t         e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_RD:    act = rdata;
                K_XT:    act = excptype;
                K_EP:    act = epc;
                default: act = {31'b0, timer_int};
            endcase
            n_vec++;
            if (act !== e.exp) begin
                n_miss++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end else begin
                $display("ok   %s: 0x%08h", e.name, act);
            end
        end
    end

    task automatic want(input string n, input int k, input logic [31:0] v);
        sb_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        we        = 1'b0;
        excpt     = 1'b0;
        syscall_i = 1'b0;
        eret_i    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = 5'd9;
        pc_i = '0; syscall_i = 1'b0; eret_i = 1'b0; excpt = 1'b0;
        step(); step();
        want("rst_count", K_RD, 32'h0);
        want("rst_excptype", K_XT, 32'h0);
        want("rst_epc", K_EP, 32'h0);
        want("rst_timer", K_TI, 32'h0);
        step();
        raddr = 5'd12;
        want("rst_status", K_RD, 32'h0000_8001);
        step();

        // Count 0 here; every step below advances it by one.
        rst = 1'b1; raddr = 5'd9;
        repeat (10) step();
        want("count10", K_RD, 32'd10);
        want("idle_xt", K_XT, 32'h0);
        step();
        raddr = 5'd12; want("status_8001", K_RD, 32'h0000_8001);
        we = 1'b1; waddr = 5'd11; wdata = 32'd20;
        step();
        raddr = 5'd9;
        repeat (8) begin
            want("pre_match_timer", K_TI, 32'h0);
            step();
        end
        want("match_count", K_RD, 32'd20);
        want("match_timer", K_TI, 32'h0);
        step();
        want("timer_rise", K_TI, 32'h1);
        want("timer_xt", K_XT, 32'h4);
        raddr = 5'd13; want("cause_ip7", K_RD, 32'h0000_8000);
        pc_i = 32'h40; excpt = 1'b1;
        step();
        raddr = 5'd12; want("exl_set", K_RD, 32'h0000_8003);
        want("timer_epc", K_EP, 32'h40);
        want("masked_xt", K_XT, 32'h0);
        want("ip7_held", K_TI, 32'h1);
        step();
        raddr = 5'd13; want("timer_exccode", K_RD, 32'h0000_8000);
        eret_i = 1'b1; excpt = 1'b1;
        want("eret_xt", K_XT, 32'h200);
        step();
        syscall_i = 1'b1;
        want("prio_xt", K_XT, 32'h4);
        we = 1'b1; waddr = 5'd11; wdata = 32'h0;
        step();
        want("ip7_clr", K_TI, 32'h0);
        syscall_i = 1'b1; pc_i = 32'h3C; excpt = 1'b1;
        want("sys_xt", K_XT, 32'h100);
        step();
        raddr = 5'd13; want("sys_exccode", K_RD, 32'h20);
        want("sys_epc", K_EP, 32'h3C);
        syscall_i = 1'b1;
        want("held_sys_xt", K_XT, 32'h0);
        step();
        eret_i = 1'b1; excpt = 1'b1;
        want("eret2_xt", K_XT, 32'h200);
        want("eret_epc", K_EP, 32'h3C);
        step();
        raddr = 5'd12; want("exl_clr", K_RD, 32'h0000_8001);
        step();
        raddr = 5'd14; we = 1'b1; waddr = 5'd14; wdata = 32'h100; eret_i = 1'b1;
        want("byp_epc", K_EP, 32'h100);
        want("byp_rdata", K_RD, 32'h100);
        step();
        want("epc_reg", K_RD, 32'h100);
        step();
        raddr = 5'd13; we = 1'b1; waddr = 5'd13; wdata = 32'hFFFF_FFFF;
        want("cause_byp", K_RD, 32'h320);
        step();
        want("cause_ro", K_RD, 32'h320);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD;
        step();
        raddr = 5'd5; want("unmapped", K_RD, 32'h0);
        step();
        syscall_i = 1'b1; pc_i = 32'h80; excpt = 1'b1;
        we = 1'b1; waddr = 5'd12; wdata = 32'h0; raddr = 5'd12;
        want("st_byp", K_RD, 32'h0);
        step();
        want("st_merge", K_RD, 32'h2);
        want("st_epc", K_EP, 32'h80);
        step();
        we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFE; raddr = 5'd9;
        step();
        want("cnt_fffe", K_RD, 32'hFFFF_FFFE);
        step();
        step();
        want("cnt_wrap", K_RD, 32'h0);
        step();

        // Reset asserted between edges: values must clear before the next edge.
        rst = 1'b0; raddr = 5'd12;
        want("arst_status", K_RD, 32'h0000_8001);
        want("arst_epc", K_EP, 32'h0);
        want("arst_xt", K_XT, 32'h0);
        step();
        raddr = 5'd14; want("arst_epcreg", K_RD, 32'h0);
        step();
        raddr = 5'd9; want("arst_count", K_RD, 32'h0);
        step();
        rst = 1'b1;
        step();
        want("post_rst_count", K_RD, 32'h1);
        step();
        step();
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
